// File: rtl/digit_entry.sv
// Debounced enter-key digit capture with per-sequence digit counting.
// A clean press latches sw[3:0] and emits a one-cycle digit_valid strobe,
// plus seq_done when the sequence fills up.
module digit_entry #(
    parameter int unsigned DB_CYCLES  = 50000,
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic [9:0] sw,
    input  logic       clear,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic       digit_err,
    output logic [2:0] count,
    output logic       seq_done
);

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StPressed,
        StReleaseChk
    } db_state_e;

    localparam logic [15:0] DbLast    = 16'(DB_CYCLES - 1);
    localparam logic [2:0]  NumDigits = 3'(NUM_DIGITS);

    logic        key_meta_q;
    logic        key_s_q;
    db_state_e   state_q, state_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        accept;
    logic        capture;
    logic        pend_q;
    logic        valid_q;
    logic        done_q;
    logic [3:0]  digit_q;
    logic        err_q;
    logic [2:0]  count_q, count_d;

    // Two-flop synchronizer for the raw key; resets to the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
        end
    end

    // Debounce FSM state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StReleased;
            db_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Debounce next-state: counter restarts on every state change, so it never wraps.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        accept   = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (!key_s_q) begin
                    state_d  = StPressChk;
                    db_cnt_d = 16'd1;
                end
            end
            StPressChk: begin
                if (key_s_q) begin
                    state_d  = StReleased;
                    db_cnt_d = 16'd0;
                end else if (db_cnt_q == DbLast) begin
                    state_d  = StPressed;
                    db_cnt_d = 16'd0;
                    accept   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 16'd1;
                end
            end
            StPressed: begin
                if (key_s_q) begin
                    state_d  = StReleaseChk;
                    db_cnt_d = 16'd1;
                end
            end
            StReleaseChk: begin
                if (!key_s_q) begin
                    state_d  = StPressed;
                    db_cnt_d = 16'd0;
                end else if (db_cnt_q == DbLast) begin
                    state_d  = StReleased;
                    db_cnt_d = 16'd0;
                end else begin
                    db_cnt_d = db_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = StReleased;
                db_cnt_d = 16'd0;
            end
        endcase
    end

    // Sequence next-state: clear discards a coincident acceptance and zeroes the count.
    always_comb begin
        capture = accept && !clear && (count_q < NumDigits);
        count_d = count_q;
        if (clear) begin
            count_d = 3'd0;
        end else if (pend_q) begin
            count_d = count_q + 3'd1;
        end
    end

    // Digit capture at acceptance; strobes follow one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 3'd0;
        end else begin
            if (capture) begin
                digit_q <= sw[3:0];
                err_q   <= (sw > 10'd9);
            end
            pend_q  <= capture;
            valid_q <= pend_q && !clear;
            done_q  <= pend_q && !clear && (count_q == NumDigits - 3'd1);
            count_q <= count_d;
        end
    end

    assign digit_valid = valid_q;
    assign digit       = digit_q;
    assign digit_err   = err_q;
    assign count       = count_q;
    assign seq_done    = done_q;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: directed cases plus random key/switch/clear traffic,
// every cycle compared against a run-length reference model.
module tb_digit_entry;

    localparam int unsigned DB = 4;
    localparam int unsigned ND = 6;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       key_n = 1'b1;
    logic       clear = 1'b0;
    logic [9:0] sw    = 10'd0;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_err;
    logic [2:0] count;
    logic       seq_done;

    digit_entry #(
        .DB_CYCLES (DB),
        .NUM_DIGITS(ND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw         (sw),
        .clear      (clear),
        .digit_valid(digit_valid),
        .digit      (digit),
        .digit_err  (digit_err),
        .count      (count),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    int dones    = 0;

    // Reference model: key delayed two samples, debounced level flips after DB
    // consecutive samples that disagree with it.
    logic       m_k1, m_k2, m_lvl;
    int         m_run;
    logic       m_pend, m_valid, m_done, m_err;
    logic [3:0] m_digit;
    int         m_cnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k1 = 1'b1; m_k2 = 1'b1; m_lvl = 1'b1; m_run = 0;
        m_pend = 1'b0; m_valid = 1'b0; m_done = 1'b0;
        m_err = 1'b0; m_digit = 4'd0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic nv, nd, np;
        int   nc;
        if (rst) begin
            model_reset();
            return;
        end
        nv = m_pend && !clear;
        nd = nv && (m_cnt == ND - 1);
        nc = clear ? 0 : (m_pend ? m_cnt + 1 : m_cnt);
        np = 1'b0;
        if (m_k2 != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl = m_k2;
                m_run = 0;
                if (!m_k2 && !clear && m_cnt < ND) begin
                    m_digit = sw[3:0];
                    m_err   = (sw > 10'd9);
                    np      = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        m_k2 = m_k1; m_k1 = key_n;
        m_valid = nv; m_done = nd; m_cnt = nc; m_pend = np;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("m_valid", 16'(digit_valid), 16'(m_valid));
        chk("m_done", 16'(seq_done), 16'(m_done));
        chk("m_digit", 16'(digit), 16'(m_digit));
        chk("m_err", 16'(digit_err), 16'(m_err));
        chk("m_count", 16'(count), 16'(m_cnt));
        if (digit_valid === 1'b1) strobes++;
        if (seq_done === 1'b1) dones++;
    endtask

    task automatic press(input logic [9:0] v);
        sw    = v;
        key_n = 1'b0;
        repeat (10) cyc();
        key_n = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 16'(digit_valid), 16'd0);
        chk({tag, "_done"}, 16'(seq_done), 16'd0);
        chk({tag, "_digit"}, 16'(digit), 16'd0);
        chk({tag, "_err"}, 16'(digit_err), 16'd0);
        chk({tag, "_count"}, 16'(count), 16'd0);
    endtask

    logic [9:0] vals [6];
    int s0, d0;

    initial begin
        vals = '{10'd2, 10'd8, 10'd5, 10'd5, 10'd9, 10'd1};
        model_reset();
        #2;
        check_reset_outputs("reset");
        repeat (2) cyc();
        rst = 1'b0;

        // Single clean press: strobe exactly DB+3 cycles after key goes low.
        sw = 10'd2; key_n = 1'b0; s0 = strobes;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("latency_valid", 16'(digit_valid), 16'(i == DB + 3));
        end
        chk("p1_strobes", 16'(strobes - s0), 16'd1);
        chk("p1_digit", 16'(digit), 16'd2);
        chk("p1_err", 16'(digit_err), 16'd0);
        chk("p1_count", 16'(count), 16'd1);
        key_n = 1'b1;
        repeat (12) cyc();

        // Bouncy key: rejected; a clean press afterwards shows normal latency.
        s0 = strobes;
        key_n = 1'b0; repeat (2) cyc();
        key_n = 1'b1; cyc();
        key_n = 1'b0; repeat (2) cyc();
        key_n = 1'b1; repeat (12) cyc();
        chk("bounce_strobes", 16'(strobes - s0), 16'd0);
        chk("bounce_count", 16'(count), 16'd1);
        sw = 10'd7; key_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("after_bounce_valid", 16'(digit_valid), 16'(i == DB + 3));
        end
        key_n = 1'b1;
        repeat (10) cyc();
        chk("after_bounce_count", 16'(count), 16'd2);

        // Full sequence, then an overflow press.
        do_clear();
        chk("clr_count", 16'(count), 16'd0);
        d0 = dones;
        for (int i = 0; i < 6; i++) begin
            s0 = strobes;
            press(vals[i]);
            chk("seq_strobe", 16'(strobes - s0), 16'd1);
            chk("seq_count", 16'(count), 16'(i + 1));
            chk("seq_digit", 16'(digit), 16'(vals[i][3:0]));
        end
        chk("seq_done_cnt", 16'(dones - d0), 16'd1);
        s0 = strobes;
        press(10'd4);
        chk("over_strobe", 16'(strobes - s0), 16'd0);
        chk("over_count", 16'(count), 16'd6);
        chk("over_digit", 16'(digit), 16'd1);
        chk("over_done", 16'(dones - d0), 16'd1);

        // Out-of-range switch values.
        do_clear();
        press(10'h00C);
        chk("errC_digit", 16'(digit), 16'hC);
        chk("errC_err", 16'(digit_err), 16'd1);
        chk("errC_count", 16'(count), 16'd1);
        press(10'h201);
        chk("err201_digit", 16'(digit), 16'h1);
        chk("err201_err", 16'(digit_err), 16'd1);
        chk("err201_count", 16'(count), 16'd2);

        // Clear coinciding with acceptance of the third press.
        do_clear();
        press(10'd3);
        press(10'd4);
        s0 = strobes;
        sw = 10'd6; key_n = 1'b0;
        repeat (DB + 1) cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
        repeat (9) cyc();
        key_n = 1'b1;
        repeat (10) cyc();
        chk("clrwin_strobe", 16'(strobes - s0), 16'd0);
        chk("clrwin_count", 16'(count), 16'd0);
        chk("clrwin_digit", 16'(digit), 16'd4);
        press(10'd5);
        chk("clrwin_next_count", 16'(count), 16'd1);

        // Asynchronous reset mid-debounce with count=4, key kept low.
        do_clear();
        for (int i = 0; i < 4; i++) press(10'(i + 1));
        chk("pre_rst_count", 16'(count), 16'd4);
        sw = 10'd3; key_n = 1'b0;
        repeat (3) cyc();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        cyc();
        #2 rst = 1'b0;
        s0 = strobes;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("post_rst_valid", 16'(digit_valid), 16'(i == DB + 3));
        end
        chk("post_rst_strobes", 16'(strobes - s0), 16'd1);
        chk("post_rst_count", 16'(count), 16'd1);
        chk("post_rst_digit", 16'(digit), 16'd3);
        key_n = 1'b1;
        repeat (10) cyc();

        // Random key segments, switch values, clears and occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            key_n = 1'($urandom_range(0, 1));
            sw    = 10'($urandom);
            len   = int'($urandom_range(1, 12));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                cyc();
                #2 rst = 1'b0;
            end
            clear = ($urandom_range(0, 29) == 0);
            cyc();
            clear = 1'b0;
            repeat (len - 1) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, meaning the number of consecutive stable synchronized samples required to accept a button level change (legal range 2..65535).
REQ-002 SHALL have parameter NUM_DIGITS, default 6, meaning the number of digits in one combination sequence (legal range 1..7).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_n  input  1  raw enter pushbutton, active-low, asynchronous to clk, may bounce.
REQ-006 SHALL have port sw  input  10  raw slide switches, quasi-static; the digit value to enter.
REQ-007 SHALL have port clear  input  1  synchronous sequence restart, active-high, already synchronous to clk.
REQ-008 SHALL have port digit_valid  output  1  one-cycle strobe: a debounced press was accepted.
REQ-009 SHALL have port digit  output  4  sw[3:0] captured at the accepted press; held until the next accepted press.
REQ-010 SHALL have port digit_err  output  1  set with digit_valid when captured sw > 9 (any of sw[9:4] set or sw[3:0] > 9); held with digit.
REQ-011 SHALL have port count  output  3  digits accepted in the current sequence, 0..NUM_DIGITS.
REQ-012 SHALL have port seq_done  output  1  one-cycle strobe coincident with the digit_valid that makes count reach NUM_DIGITS.

Function
REQ-013 SHALL pass key_n through a two-flop synchronizer, reset value 1 (released); only the second flop output (key_s) is used downstream.
REQ-014 SHALL implement a 4-state debounce FSM: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-015 RELEASED: key_s=0 -> PRESS_CHK with debounce counter loaded to 1; else stay.
REQ-016 PRESS_CHK: key_s=1 -> RELEASED (bounce rejected); key_s=0 and counter = DB_CYCLES-1 -> PRESSED; otherwise counter +1.
REQ-017 PRESSED: key_s=1 -> RELEASE_CHK with counter loaded to 1; else stay (a held button produces no further strobes).
REQ-018 RELEASE_CHK: key_s=0 -> PRESSED; key_s=1 and counter = DB_CYCLES-1 -> RELEASED; otherwise counter +1.
REQ-019 The debounce counter SHALL be 16 bits and never wrap: it resets on every state change and cannot exceed DB_CYCLES-1.
REQ-020 On the PRESS_CHK->PRESSED transition, the block SHALL register digit<=sw[3:0] and digit_err<=(sw>9), and SHALL assert digit_valid in the next cycle, for exactly one cycle, provided count < NUM_DIGITS.
REQ-021 Latency: with key_n held low from cycle 0 and no bounce, digit_valid SHALL be high in cycle DB_CYCLES+3.
REQ-022 Each digit_valid SHALL increment count by 1 whether or not digit_err is set.
REQ-023 When count = NUM_DIGITS, further accepted presses SHALL produce neither digit_valid nor seq_done; digit, digit_err, and count are unchanged; the FSM still tracks the button.
REQ-024 clear=1 SHALL set count to 0 next cycle; if clear coincides with a press acceptance, the press SHALL be discarded (clear wins), and digit/digit_err are unchanged.
REQ-025 clear SHALL NOT affect the debounce FSM; a button held through clear produces no strobe until released and pressed again.
REQ-026 sw changes SHALL have no effect except at the capture cycle in REQ-020.

Reset
REQ-027 While rst=1, the block SHALL hold all flops asynchronously as follows: synchronizer=1, FSM=RELEASED, counter=0, digit=0, digit_err=0, count=0, digit_valid=0, seq_done=0.
REQ-028 If rst is deasserted while key_n is low, the block SHALL treat this as a new press and debounce it normally (REQ-015..020).
REQ-029 Reset asserted mid-debounce or mid-sequence SHALL abandon the pending press and sequence; there SHALL be no strobe during or on exit from reset.

Verification (DB_CYCLES=4, NUM_DIGITS=6)
REQ-030 Case: sw=2, key_n low at cycle 0 held 20 cycles -> digit_valid high in cycle 7 only; digit=2, digit_err=0, count=1.
REQ-031 Case: key_n glitches low 2 cycles, high 1, low 2, then high -> no digit_valid; FSM returns to RELEASED.
REQ-032 Case: six clean presses with sw=2,8,5,5,9,1 -> six strobes, count 1..6; seq_done coincident with the 6th strobe; a 7th press -> no strobe, count stays 6.
REQ-033 Case: press with sw=10'h00C, then one with sw=10'h201 -> digit=C, digit_err=1, then digit=1, digit_err=1; count increments both times.
REQ-034 Case: clear asserted in the capture cycle of the 3rd press -> no strobe, count=0; the next press gives count=1.
REQ-035 Case: rst pulsed high for 1 cycle (asynchronously) during PRESS_CHK with count=4 -> outputs are reset values immediately; with key_n still low, exactly one strobe follows DB_CYCLES+3 cycles after release, and count=1.
